// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus port among NUM_INPUTS cache masters.
// The grant is held for a whole burst; beats are counted against the burst length.
package cbus_pkg;
    typedef logic [7:0] mlen_t;  // burst length in beats-1
    localparam mlen_t MLEN1   = 8'd0;
    localparam mlen_t MLEN2   = 8'd1;
    localparam mlen_t MLEN4   = 8'd3;
    localparam mlen_t MLEN8   = 8'd7;
    localparam mlen_t MLEN16  = 8'd15;
    localparam mlen_t MLEN256 = 8'd255;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        mlen_t       len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t [NUM_INPUTS-1:0]  ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        proto_err
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [8:0]         beat_q,  beat_d;
    logic               err_q,   err_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               len_match;

    // First valid requester at or after ptr_q, wrapping modulo NUM_INPUTS.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_INPUTS);
            if (!found && ireqs[cand].valid) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        err_d     = err_q;
        oreq      = '0;
        iresps    = '0;
        len_match = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = pick;
                    beat_d  = '0;
                end
            end
            BUSY: begin
                oreq            = ireqs[grant_q];
                iresps[grant_q] = oresp;
                // A count of 256 or more can never match an 8-bit length.
                len_match = !beat_q[8] && (beat_q[7:0] == oreq.len);
                if (oresp.ready) begin
                    beat_d = (beat_q == '1) ? beat_q : beat_q + 9'd1;
                    if (oresp.last) begin
                        state_d = IDLE;
                        ptr_d   = (grant_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                        if (!len_match) err_d = 1'b1;
                    end else if (len_match) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;
    assign proto_err = err_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, rotation and beat accounting.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset;
    cbus_req_t  [N-1:0]  ireqs;
    cbus_resp_t [N-1:0]  iresps;
    cbus_req_t           oreq;
    cbus_resp_t          oresp;
    logic                busy;
    logic [1:0]          grant_idx;
    logic                proto_err;

    cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .busy(busy), .grant_idx(grant_idx),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // drive values applied on the next step
    cbus_req_t  [N-1:0] d_req;
    cbus_resp_t         d_resp;
    logic               d_rst;

    // model: who owns the bus, how many beats it has taken, where the rotation resumes
    bit m_busy;
    int m_gnt, m_ptr, m_beats;
    bit m_err;

    // grants observed on the DUT, in order
    int  dq[$];
    bit  prev_busy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        cbus_req_t  eq;
        cbus_resp_t er;
        @(negedge clk);
        ireqs = d_req; oresp = d_resp; reset = d_rst;
        #1;
        chk("busy", busy, m_busy);
        chk("grant_idx", grant_idx, 128'(m_gnt));
        chk("proto_err", proto_err, m_err);
        eq = m_busy ? d_req[m_gnt] : '0;
        chk("oreq", oreq, eq);
        for (int j = 0; j < N; j++) begin
            er = (m_busy && j == m_gnt) ? d_resp : '0;
            chk($sformatf("iresp%0d", j), iresps[j], er);
        end
        if (busy && !prev_busy) dq.push_back(int'(grant_idx));
        prev_busy = busy;
        if (d_rst) begin
            m_busy = 0; m_gnt = 0; m_ptr = 0; m_beats = 0; m_err = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (d_req[idx].valid) begin
                    m_busy = 1; m_gnt = idx; m_beats = 0;
                    break;
                end
            end
        end else if (d_resp.ready) begin
            if (d_resp.last) begin
                if (m_beats != int'(d_req[m_gnt].len)) m_err = 1;
                m_busy = 0;
                m_ptr  = (m_gnt + 1) % N;
            end else if (m_beats == int'(d_req[m_gnt].len)) begin
                m_err = 1;
            end
            m_beats++;
        end
    endtask

    // let the next edge land, then look at registered state
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input mlen_t len);
        cbus_req_t r;
        r.valid = 1'b1; r.is_write = 1'($urandom); r.addr = $urandom;
        r.len = len; r.strobe = 4'($urandom); r.data = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        d_req = '0; d_resp = '0; d_rst = 1'b1;
        step(); step();
        d_rst = 1'b0;
    endtask

    // n ready beats, with last raised on beat last_at (0 = never)
    task automatic beats(input int n, input int last_at);
        for (int b = 1; b <= n; b++) begin
            d_resp.ready = 1'b1;
            d_resp.last  = (b == last_at);
            d_resp.data  = $urandom;
            step();
        end
        d_resp = '0;
    endtask

    initial begin
        m_busy = 0; m_gnt = 0; m_ptr = 0; m_beats = 0; m_err = 0; prev_busy = 0;
        d_req = '0; d_resp = '0; d_rst = 1'b1;
        ireqs = '0; oresp = '0; reset = 1'b1;
        do_reset();
        settle();
        chk("reset_busy", busy, 1'b0);
        chk("reset_grant", grant_idx, 2'd0);
        chk("reset_err", proto_err, 1'b0);

        // dcache alone, single beat, completes on 2nd busy cycle
        d_req[1] = mk_req(MLEN1);
        step();
        settle();
        chk("t1_grant", grant_idx, 2'd1);
        chk("t1_busy", busy, 1'b1);
        step();
        d_resp.ready = 1'b1; d_resp.last = 1'b1; d_resp.data = 32'hCAFE_0001;
        step();
        chk("t1_data", iresps[1].data, 32'hCAFE_0001);
        d_resp = '0; d_req = '0;
        settle();
        chk("t1_idle", busy, 1'b0);
        chk("t1_err", proto_err, 1'b0);

        // both valid together after reset: icache first, then dcache after one idle cycle
        do_reset();
        dq.delete();
        d_req[0] = mk_req(MLEN2);
        d_req[1] = mk_req(MLEN2);
        step();
        beats(2, 2);
        d_req[0] = '0;
        step();
        step();
        beats(2, 2);
        d_req = '0;
        step();
        chk("t2_n", dq.size(), 2);
        chk("t2_first", dq[0], 0);
        chk("t2_second", dq[1], 1);

        // icache 16-beat read while dcache waits
        do_reset();
        dq.delete();
        d_req[0] = mk_req(MLEN16);
        d_req[1] = mk_req(MLEN4);
        step();
        beats(16, 16);
        d_req[0] = '0;
        step();
        step();
        beats(4, 4);
        d_req = '0;
        step();
        chk("t3_order", {dq[0], dq[1]}, {32'd0, 32'd1});
        chk("t3_err", proto_err, 1'b0);

        // MLEN4 burst ended early on beat 3
        do_reset();
        d_req[0] = mk_req(MLEN4);
        step();
        beats(3, 3);
        d_req = '0;
        settle();
        chk("t4_err", proto_err, 1'b1);
        repeat (5) step();
        settle();
        chk("t4_sticky", proto_err, 1'b1);

        // reset during beat 5 of an MLEN8 burst
        do_reset();
        d_req[0] = mk_req(MLEN8);
        step();
        beats(4, 0);
        d_resp.ready = 1'b1;
        d_rst = 1'b1;
        step();
        d_rst = 1'b0; d_resp = '0;
        settle();
        chk("t5_busy", busy, 1'b0);
        chk("t5_oreq_valid", oreq.valid, 1'b0);
        chk("t5_ready", {iresps[0].ready, iresps[1].ready, iresps[2].ready}, 3'b000);
        chk("t5_err", proto_err, 1'b0);

        // all three valid continuously: strict rotation
        do_reset();
        dq.delete();
        for (int i = 0; i < N; i++) d_req[i] = mk_req(MLEN1);
        repeat (6) begin
            step();
            beats(1, 1);
        end
        d_req = '0;
        step();
        chk("t6_n", dq.size(), 6);
        for (int i = 0; i < 6 && i < dq.size(); i++)
            chk($sformatf("t6_order%0d", i), dq[i], i % N);

        // random traffic; the grantee holds its request, the adapter mostly ends bursts correctly
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!(m_busy && i == m_gnt)) begin
                    if ($urandom_range(0, 1) == 1) d_req[i] = mk_req(mlen_t'($urandom_range(0, 5)));
                    else d_req[i] = '0;
                end
            d_resp.ready = 1'($urandom_range(0, 1));
            d_resp.data  = $urandom;
            if (m_busy && m_beats == int'(d_req[m_gnt].len))
                d_resp.last = d_resp.ready && ($urandom_range(0, 9) != 0);
            else
                d_resp.last = d_resp.ready && ($urandom_range(0, 19) == 0);
            d_rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
